// File: rtl/axi_read_burst_engine_if.sv
// Bundle of request-FIFO, backend and AXI R channel signals for the read burst engine.
// The master modport is the engine side; slave is the FIFO/backend/AXI master side.
interface axi_read_burst_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] ADDRESS_IN;
  logic [7:0]        ARLEN_IN;
  logic [2:0]        ARSIZE_IN;
  logic [1:0]        ARBURST_IN;
  logic [5:0]        R_ID_IN;
  logic [2:0]        R_PROT_IN;
  logic              req_pop;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_prot;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  logic              RVALID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic [5:0]        RID;
  logic              RLAST;
  logic              RREADY;

  logic [7:0]        Beat_Count;
  logic              busy;

  modport master (
    input  req_valid, ADDRESS_IN, ARLEN_IN, ARSIZE_IN, ARBURST_IN, R_ID_IN, R_PROT_IN,
    input  mem_ack, mem_rdata, mem_err, RREADY,
    output req_pop, mem_req, mem_addr, mem_prot,
    output RVALID, RDATA, RRESP, RID, RLAST, Beat_Count, busy
  );

  modport slave (
    output req_valid, ADDRESS_IN, ARLEN_IN, ARSIZE_IN, ARBURST_IN, R_ID_IN, R_PROT_IN,
    output mem_ack, mem_rdata, mem_err, RREADY,
    input  req_pop, mem_req, mem_addr, mem_prot,
    input  RVALID, RDATA, RRESP, RID, RLAST, Beat_Count, busy
  );
endinterface

// File: rtl/axi_read_burst_engine.sv
// Pops one AR request, walks its beats (FIXED/INCR/WRAP), fetches each word from the backend
// and returns it on the AXI R channel. One burst in flight at a time.
module axi_read_burst_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                    clk,
  input logic                    reset,
  axi_read_burst_engine_if.master bus
);

  typedef enum logic [1:0] {StIdle, StMemRd, StRSend} state_e;

  state_e            state_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              illegal_q;

  logic              req_legal;
  logic              wrap_len;
  logic [ADDR_W-1:0] step_sz;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;

  assign req_legal = (bus.ARBURST_IN != 2'b11) && (bus.ARSIZE_IN <= 3'd2);
  // Gated by reset so the strobe also reads 0 while reset is held.
  assign bus.req_pop = reset && bus.req_valid && (state_q == StIdle);
  assign bus.busy    = (state_q != StIdle);

  always_comb begin
    step_sz   = ADDR_W'(1) << size_q;
    incr_addr = bus.mem_addr + step_sz;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    wrap_len  = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    next_addr = incr_addr;
    case (burst_q)
      2'b00: next_addr = bus.mem_addr;
      2'b10: begin
        // Non-power-of-two WRAP lengths fall back to INCR stepping.
        if (wrap_len) next_addr = (bus.mem_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      default: next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      illegal_q      <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_prot   <= '0;
      bus.RVALID     <= 1'b0;
      bus.RDATA      <= '0;
      bus.RRESP      <= '0;
      bus.RID        <= '0;
      bus.RLAST      <= 1'b0;
      bus.Beat_Count <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            len_q          <= bus.ARLEN_IN;
            size_q         <= bus.ARSIZE_IN;
            burst_q        <= bus.ARBURST_IN;
            illegal_q      <= !req_legal;
            bus.mem_addr   <= bus.ADDRESS_IN;
            bus.mem_prot   <= bus.R_PROT_IN;
            bus.RID        <= bus.R_ID_IN;
            bus.Beat_Count <= '0;
            if (req_legal) begin
              bus.mem_req <= 1'b1;
              state_q     <= StMemRd;
            end else begin
              // Illegal requests answer every beat with SLVERR and no backend access.
              bus.RVALID <= 1'b1;
              bus.RDATA  <= '0;
              bus.RRESP  <= 2'b10;
              bus.RLAST  <= (bus.ARLEN_IN == 8'd0);
              state_q    <= StRSend;
            end
          end
        end
        StMemRd: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.RDATA   <= bus.mem_rdata;
            bus.RRESP   <= bus.mem_err ? 2'b10 : 2'b00;
            bus.RVALID  <= 1'b1;
            bus.RLAST   <= (bus.Beat_Count == len_q);
            state_q     <= StRSend;
          end
        end
        StRSend: begin
          if (bus.RREADY) begin
            if (bus.RLAST) begin
              bus.RVALID <= 1'b0;
              bus.RLAST  <= 1'b0;
              state_q    <= StIdle;
            end else begin
              bus.Beat_Count <= bus.Beat_Count + 8'd1;
              bus.mem_addr   <= next_addr;
              if (illegal_q) begin
                bus.RLAST <= ((bus.Beat_Count + 8'd1) == len_q);
              end else begin
                bus.RVALID  <= 1'b0;
                bus.mem_req <= 1'b1;
                state_q     <= StMemRd;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_burst_engine.sv
// Directed bench for axi_read_burst_engine: zero-wait backend model, beat logger and
// hand-computed expectations for INCR, WRAP, FIXED with stall, illegal, error and reset cases.
module tb_axi_read_burst_engine;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_bad    = 0;

  axi_read_burst_engine_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_read_burst_engine #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Zero-wait backend; data encodes the beat address so each beat is identifiable.
  logic        err_on;
  logic [31:0] err_addr;
  assign bus.mem_ack   = bus.mem_req;
  assign bus.mem_rdata = 32'hD00D0000 | {16'h0000, bus.mem_addr[15:0]};
  assign bus.mem_err   = bus.mem_req && err_on && (bus.mem_addr == err_addr);

  logic [31:0] addr_q  [$];
  logic [31:0] rdata_q [$];
  logic [1:0]  rresp_q [$];
  logic [5:0]  rid_q   [$];
  logic        rlast_q [$];
  logic [7:0]  bcnt_q  [$];
  int          pop_cnt;
  int          mem_req_cycles;

  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack) addr_q.push_back(bus.mem_addr);
    if (bus.mem_req) mem_req_cycles++;
    if (bus.req_pop) pop_cnt++;
    if (bus.RVALID && bus.RREADY) begin
      rdata_q.push_back(bus.RDATA);
      rresp_q.push_back(bus.RRESP);
      rid_q.push_back(bus.RID);
      rlast_q.push_back(bus.RLAST);
      bcnt_q.push_back(bus.Beat_Count);
    end
  end

  logic [31:0] ea [16];
  logic [1:0]  er [16];
  logic [7:0]  stall_beat;
  int          stall_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    rdata_q.delete();
    rresp_q.delete();
    rid_q.delete();
    rlast_q.delete();
    bcnt_q.delete();
    pop_cnt        = 0;
    mem_req_cycles = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_pop"}, 32'(bus.req_pop), 0);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_prot"}, 32'(bus.mem_prot), 0);
    check({tag, "_rvalid"}, 32'(bus.RVALID), 0);
    check({tag, "_rdata"}, bus.RDATA, 0);
    check({tag, "_rresp"}, 32'(bus.RRESP), 0);
    check({tag, "_rid"}, 32'(bus.RID), 0);
    check({tag, "_rlast"}, 32'(bus.RLAST), 0);
    check({tag, "_beat_count"}, 32'(bus.Beat_Count), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // Issues one request from IDLE and runs it to completion; cycles counts from pop+1 to IDLE.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input logic [2:0] prot,
                           input bit legal, input bit hold_valid, output int cycles);
    logic [31:0] snap_data;
    logic [1:0]  snap_resp;
    logic        snap_last;
    clear_logs();
    bus.ADDRESS_IN = addr;
    bus.ARLEN_IN   = len;
    bus.ARSIZE_IN  = size;
    bus.ARBURST_IN = burst;
    bus.R_ID_IN    = id;
    bus.R_PROT_IN  = prot;
    bus.RREADY     = 1'b1;
    bus.req_valid  = 1'b1;
    #1;
    check("pop_strobe", 32'(bus.req_pop), 1);
    step();
    if (!hold_valid) bus.req_valid = 1'b0;
    if (legal) begin
      check("first_mem_req", 32'(bus.mem_req), 1);
      check("first_mem_prot", 32'(bus.mem_prot), 32'(prot));
    end else begin
      check("first_rvalid_illegal", 32'(bus.RVALID), 1);
    end
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      if (bus.RVALID && bus.Beat_Count == stall_beat && stall_left > 0) begin
        if (stall_left == 3) begin
          snap_data = bus.RDATA;
          snap_resp = bus.RRESP;
          snap_last = bus.RLAST;
        end else begin
          check("stall_rdata", bus.RDATA, snap_data);
          check("stall_rresp", 32'(bus.RRESP), 32'(snap_resp));
          check("stall_rlast", 32'(bus.RLAST), 32'(snap_last));
          check("stall_rvalid", 32'(bus.RVALID), 1);
        end
        bus.RREADY = 1'b0;
        stall_left--;
      end else begin
        bus.RREADY = 1'b1;
      end
      if (bus.RVALID && bus.RREADY && bus.RLAST) bus.req_valid = 1'b0;
      step();
      cycles++;
    end
    check("burst_bounded", 32'(cycles < 200), 1);
    bus.req_valid = 1'b0;
    bus.RREADY    = 1'b1;
  endtask

  task automatic verify_burst(input string tag, input int beats, input logic [5:0] id,
                              input bit legal);
    check({tag, "_beats"}, 32'(rdata_q.size()), 32'(beats));
    for (int i = 0; i < beats; i++) begin
      if (legal) begin
        check($sformatf("%s_addr%0d", tag, i), addr_q[i], ea[i]);
        check($sformatf("%s_rdata%0d", tag, i), rdata_q[i], 32'hD00D0000 | {16'h0, ea[i][15:0]});
      end else begin
        check($sformatf("%s_rdata%0d", tag, i), rdata_q[i], 0);
      end
      check($sformatf("%s_rresp%0d", tag, i), 32'(rresp_q[i]), 32'(er[i]));
      check($sformatf("%s_rid%0d", tag, i), 32'(rid_q[i]), 32'(id));
      check($sformatf("%s_rlast%0d", tag, i), 32'(rlast_q[i]), 32'(i == beats - 1));
      check($sformatf("%s_bcnt%0d", tag, i), 32'(bcnt_q[i]), 32'(i));
    end
    if (legal) check({tag, "_mem_beats"}, 32'(addr_q.size()), 32'(beats));
    else check({tag, "_no_mem_req"}, 32'(mem_req_cycles), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int lasts;
    bit reached;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.ADDRESS_IN = '0;
    bus.ARLEN_IN   = '0;
    bus.ARSIZE_IN  = '0;
    bus.ARBURST_IN = '0;
    bus.R_ID_IN    = '0;
    bus.R_PROT_IN  = '0;
    bus.RREADY     = 1'b1;
    err_on         = 1'b0;
    err_addr       = '0;
    stall_beat     = 8'hFF;
    stall_left     = 0;
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // INCR 0x100, 4 beats of 4 bytes, best-case 2 cycles per beat.
    for (int i = 0; i < 4; i++) begin
      ea[i] = 32'h100 + 32'(4 * i);
      er[i] = 2'b00;
    end
    run_burst(32'h100, 8'd3, 3'd2, 2'b01, 6'h05, 3'd3, 1'b1, 1'b0, cycles);
    verify_burst("incr", 4, 6'h05, 1'b1);
    check("incr_cycles", 32'(cycles), 8);

    // WRAP over a 16-byte window starting mid-window.
    ea[0] = 32'h38; ea[1] = 32'h3C; ea[2] = 32'h30; ea[3] = 32'h34;
    run_burst(32'h38, 8'd3, 3'd2, 2'b10, 6'h11, 3'd1, 1'b1, 1'b0, cycles);
    verify_burst("wrap", 4, 6'h11, 1'b1);

    // FIXED with beat 1 stalled 3 cycles and req_valid held high throughout.
    for (int i = 0; i < 3; i++) begin
      ea[i] = 32'h20;
      er[i] = 2'b00;
    end
    stall_beat = 8'd1;
    stall_left = 3;
    run_burst(32'h20, 8'd2, 3'd2, 2'b00, 6'h07, 3'd0, 1'b1, 1'b1, cycles);
    verify_burst("fixed", 3, 6'h07, 1'b1);
    check("fixed_single_pop", 32'(pop_cnt), 1);
    check("fixed_stall_used", 32'(stall_left), 0);
    stall_beat = 8'hFF;

    // Reserved burst type: SLVERR beats, no backend traffic, one beat per cycle.
    er[0] = 2'b10; er[1] = 2'b10;
    run_burst(32'h40, 8'd1, 3'd2, 2'b11, 6'h2A, 3'd2, 1'b0, 1'b0, cycles);
    verify_burst("illegal", 2, 6'h2A, 1'b0);
    check("illegal_cycles", 32'(cycles), 2);

    // Backend error on beat 1 only; burst still completes.
    ea[0] = 32'h200; ea[1] = 32'h204; ea[2] = 32'h208;
    er[0] = 2'b00;   er[1] = 2'b10;   er[2] = 2'b00;
    err_on   = 1'b1;
    err_addr = 32'h204;
    run_burst(32'h200, 8'd2, 3'd2, 2'b01, 6'h03, 3'd0, 1'b1, 1'b0, cycles);
    verify_burst("err", 3, 6'h03, 1'b1);
    err_on = 1'b0;

    // Asynchronous reset while beat 1 sits in R_SEND.
    clear_logs();
    bus.ADDRESS_IN = 32'h300;
    bus.ARLEN_IN   = 8'd3;
    bus.ARSIZE_IN  = 3'd2;
    bus.ARBURST_IN = 2'b01;
    bus.R_ID_IN    = 6'h15;
    bus.R_PROT_IN  = 3'd5;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      if (bus.RVALID && bus.Beat_Count == 8'd1) reached = 1'b1;
      else step();
    end
    check("rst_reach_beat1", 32'(reached), 1);
    bus.RREADY = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    lasts = 0;
    foreach (rlast_q[i]) lasts += int'(rlast_q[i]);
    check("midrst_no_rlast", 32'(lasts), 0);
    step();
    reset      = 1'b1;
    bus.RREADY = 1'b1;
    step();
    ea[0] = 32'h400; ea[1] = 32'h404;
    er[0] = 2'b00;   er[1] = 2'b00;
    run_burst(32'h400, 8'd1, 3'd2, 2'b01, 6'h09, 3'd1, 1'b1, 1'b0, cycles);
    verify_burst("after_rst", 2, 6'h09, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_read_burst_engine.md
# axi_read_burst_engine

Downstream consumer of the AXI slave read-request FIFO. Pops one queued AR request (address, ID, PROT, LEN, SIZE, BURST), walks the burst beat by beat, and for each beat:
- computes the beat address (FIXED / INCR / WRAP),
- fetches one 32-bit word through a simple req/ack backend port,
- returns the word on the AXI R channel with RID, RRESP and RLAST, honouring RREADY back-pressure.

One burst is in flight at a time.

## Interface
Parameters:
- ADDR_W, 32, address width (beat address arithmetic wraps modulo 2^ADDR_W)
- DATA_W, 32, R data width; the largest legal ARSIZE is 3'd2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  FIFO holds a request (driven by the inverse of the FIFO empty flag)
- ADDRESS_IN  in  ADDR_W  start address of the request
- ARLEN_IN  in  8  beats minus 1
- ARSIZE_IN  in  3  log2 of bytes per beat
- ARBURST_IN  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- R_ID_IN  in  6  transaction ID
- R_PROT_IN  in  3  protection attributes
- req_pop  out  1  one-cycle pop strobe to the FIFO
- mem_req  out  1  backend read request
- mem_addr  out  ADDR_W  backend beat address
- mem_prot  out  3  latched PROT value
- mem_ack  in  1  backend done; samples mem_rdata and mem_err in the same cycle
- mem_rdata  in  DATA_W  backend read data
- mem_err  in  1  backend error
- RVALID  out  1  AXI R channel valid
- RDATA  out  DATA_W  AXI R channel data
- RRESP  out  2  AXI R channel response
- RID  out  6  AXI R channel ID
- RLAST  out  1  AXI R channel last-beat flag
- RREADY  in  1  AXI R channel ready from the master
- Beat_Count  out  8  index of the current beat, 0..ARLEN
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, MEM_RD, R_SEND.
- IDLE:
  - req_pop = req_valid && state==IDLE (combinational).
  - On pop, latch all request fields and set Beat_Count=0.
  - Go to MEM_RD if the request is legal; otherwise go to R_SEND.
- Illegal request: ARBURST==11 or ARSIZE>2.
  - Every beat returns RRESP=2'b10 (SLVERR) and RDATA=0.
  - mem_req is never asserted.
  - The beat count is still ARLEN+1.
- MEM_RD:
  - mem_req=1; mem_addr and mem_prot stay stable until mem_ack.
  - On mem_ack: RDATA<=mem_rdata; RRESP<=mem_err ? 2'b10 : 2'b00; go to R_SEND.
  - mem_req deasserts in the cycle after mem_ack.
- R_SEND:
  - RVALID=1 and RID=latched ID.
  - RLAST = (Beat_Count==ARLEN).
  - RDATA, RRESP, RID and RLAST hold while RVALID && !RREADY.
- On an R handshake (RVALID && RREADY):
  - If RLAST: go to IDLE.
  - Otherwise: Beat_Count+1, advance the address, then go to MEM_RD (legal request) or stay in R_SEND (illegal request).
- Address step, with s = 1<<ARSIZE:
  - FIXED: address unchanged.
  - INCR: addr+s, modulo 2^ADDR_W.
  - WRAP with ARLEN in {1,3,7,15}: window B = (ARLEN+1)*s; next = (addr & ~(B-1)) | ((addr+s) & (B-1)).
  - WRAP with any other ARLEN: treated as INCR.
- The first beat uses ADDRESS_IN unaligned and unmodified.
- A mem_err on one beat does not abort the burst; remaining beats still complete.
- Reset values (asynchronous, active-low): state=IDLE; req_pop, mem_req, mem_addr, mem_prot, RVALID, RDATA, RRESP, RID, RLAST, Beat_Count and busy are all 0.
- Reset asserted mid-burst abandons the burst immediately; no RLAST is emitted.

## Timing
- Pop in cycle 0 → mem_req=1 in cycle 1.
- mem_ack in cycle k (k≥1, zero-wait ack allowed) → RVALID=1 in cycle k+1.
- R handshake in cycle t (not the last beat) → mem_req=1 in cycle t+1.
- Last handshake in cycle t → IDLE in t+1; req_pop can fire in t+1.
- Back-to-back bursts therefore insert exactly one R-idle cycle beyond the memory latency.
- Best-case throughput with zero-wait ack and RREADY=1: one beat per 2 cycles.
- Illegal request: RVALID=1 in cycle 1, then one beat per cycle while RREADY=1.
- req_valid is ignored whenever state != IDLE.

## Test plan
- INCR, ADDRESS_IN=0x100, ARLEN=3, ARSIZE=2, zero-wait ack, RREADY=1 → mem_addr 0x100,0x104,0x108,0x10C; 4 beats; RLAST only on beat 3; Beat_Count 0..3.
- WRAP, ADDRESS_IN=0x38, ARLEN=3, ARSIZE=2 → mem_addr 0x38,0x3C,0x30,0x34.
- FIXED, ARLEN=2 at 0x20, RREADY low for 3 cycles on beat 1 → all addresses 0x20; RDATA/RRESP/RLAST stable while stalled; req_pop never asserts mid-burst.
- ARBURST=11, ARLEN=1, RID=6'h2A → 2 beats, RRESP=10, RDATA=0, RID=2A, mem_req never high.
- mem_err on beat 1 of an INCR ARLEN=2 burst → RRESP 00,10,00; burst completes with RLAST on beat 2.
- Reset pulse while in R_SEND on beat 1 → all outputs 0 asynchronously; the next request starts cleanly at Beat_Count=0.
